// File: rtl/ecg_pingpong_addr_unit.sv
// Ping-pong address generator for the interleaved ECG sample buffer (write port A, read port B).
// Build option: define ECG_ADDR_DECIM_EN to read only every DECIM-th sample of each channel.
module ecg_pingpong_addr_unit #(
  parameter int ADDR_W    = 12,
  parameter int NCH       = 2,
  parameter int BLOCK_LEN = 1024,
  parameter int DECIM     = 2,
  localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic              ovr_clr,
  output logic [ADDR_W-1:0] addra,
  output logic              wea,
  output logic [CH_W-1:0]   wr_ch,
  output logic [ADDR_W-1:0] addrb,
  output logic              addrb_valid,
  input  logic              rd_ready,
  output logic [CH_W-1:0]   rd_ch,
  output logic              rd_last,
  output logic              switch,
  output logic              block_ready,
  output logic              overrun,
  output logic              busy
);

`ifdef ECG_ADDR_DECIM_EN
  localparam int STEP = DECIM;
`else
  // DECIM has no effect in this build.
  localparam int STEP = (DECIM > 0) ? 1 : 1;
`endif

  localparam int BANK_SIZE = BLOCK_LEN * NCH;
  localparam logic [ADDR_W-1:0] BANK_A   = ADDR_W'(BANK_SIZE);
  localparam logic [ADDR_W-1:0] WR_LAST  = ADDR_W'(BANK_SIZE - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(BLOCK_LEN - STEP);
  localparam logic [ADDR_W-1:0] IDX_STEP = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] NCH_A    = ADDR_W'(NCH);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NCH - 1);

  typedef enum logic {S_IDLE, S_READ} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CH_W-1:0]   wr_ch_q, wr_ch_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              switch_q, switch_d;
  logic              block_ready_q, block_ready_d;
  logic              overrun_q, overrun_d;

  logic rd_acc, rd_done, wr_wrap, rd_idle_next, handover;

  assign wea          = sample_valid & enable;
  assign rd_acc       = addrb_valid & rd_ready;
  assign rd_done      = rd_acc & rd_last;
  assign wr_wrap      = wea & (wr_cnt_q == WR_LAST);
  assign rd_idle_next = (state_q == S_IDLE) | rd_done;
  assign handover     = wr_wrap & rd_idle_next;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (handover) state_d = S_READ;
      S_READ: if (rd_done && !handover) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == S_READ);
    addrb_valid = busy;
    rd_last     = busy & (ch_q == CH_LAST) & (idx_q == IDX_LAST);
  end

  always_comb begin
    wr_cnt_d      = wr_cnt_q;
    wr_ch_d       = wr_ch_q;
    switch_d      = switch_q;
    block_ready_d = 1'b0;
    overrun_d     = overrun_q;
    idx_d         = idx_q;
    ch_d          = ch_q;
    if (wea) begin
      if (wr_wrap) begin
        wr_cnt_d = '0;
        wr_ch_d  = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + ADDR_W'(1);
        wr_ch_d  = (wr_ch_q == CH_LAST) ? '0 : wr_ch_q + CH_W'(1);
      end
    end
    if (handover) begin
      switch_d      = ~switch_q;
      block_ready_d = 1'b1;
    end
    // A discarded block sets overrun even if a clear arrives the same cycle.
    if (wr_wrap && !rd_idle_next) overrun_d = 1'b1;
    else if (ovr_clr)             overrun_d = 1'b0;
    if (rd_acc) begin
      if (ch_q == CH_LAST) begin
        ch_d  = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_STEP;
      end else begin
        ch_d  = ch_q + CH_W'(1);
      end
    end
    if (handover) begin
      idx_d = '0;
      ch_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt_q      <= '0;
      wr_ch_q       <= '0;
      switch_q      <= 1'b0;
      block_ready_q <= 1'b0;
      overrun_q     <= 1'b0;
      idx_q         <= '0;
      ch_q          <= '0;
    end else begin
      wr_cnt_q      <= wr_cnt_d;
      wr_ch_q       <= wr_ch_d;
      switch_q      <= switch_d;
      block_ready_q <= block_ready_d;
      overrun_q     <= overrun_d;
      idx_q         <= idx_d;
      ch_q          <= ch_d;
    end
  end

  assign addra       = (switch_q ? BANK_A : '0) + wr_cnt_q;
  assign addrb       = (switch_q ? '0 : BANK_A) + idx_q * NCH_A + ADDR_W'(ch_q);
  assign wr_ch       = wr_ch_q;
  assign rd_ch       = ch_q;
  assign switch      = switch_q;
  assign block_ready = block_ready_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_ecg_pingpong_addr_unit.sv
// Directed bench for ecg_pingpong_addr_unit, default build, ADDR_W=12 NCH=2 BLOCK_LEN=4.
module tb_ecg_pingpong_addr_unit;

  logic        clk = 1'b0;
  logic        rst_n, enable, sample_valid, ovr_clr, rd_ready;
  logic [11:0] addra, addrb;
  logic        wea, addrb_valid, rd_last, switch, block_ready, overrun, busy;
  logic [0:0]  wr_ch, rd_ch;

  int n_vec = 0;
  int n_err = 0;

  ecg_pingpong_addr_unit #(.ADDR_W(12), .NCH(2), .BLOCK_LEN(4), .DECIM(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
    .ovr_clr(ovr_clr), .addra(addra), .wea(wea), .wr_ch(wr_ch), .addrb(addrb),
    .addrb_valid(addrb_valid), .rd_ready(rd_ready), .rd_ch(rd_ch), .rd_last(rd_last),
    .switch(switch), .block_ready(block_ready), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; sample_valid = 1'b0; ovr_clr = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_addra", addra, 0);
    chk("rst_addrb", addrb, 8);
    chk("rst_switch", switch, 0);
    chk("rst_valid", addrb_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last", rd_last, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_brdy", block_ready, 0);

    // enable low blocks the write
    sample_valid = 1'b1; enable = 1'b0;
    #1 chk("en0_wea", wea, 0);
    tick();
    chk("en0_addra", addra, 0);
    enable = 1'b1;

    // first block into bank 0
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("w1_addra", addra, i);
      chk("w1_wrch", wr_ch, i % 2);
      chk("w1_wea", wea, 1);
      tick();
    end
    sample_valid = 1'b0;
    chk("h1_switch", switch, 1);
    chk("h1_brdy", block_ready, 1);
    chk("h1_addrb", addrb, 0);
    chk("h1_valid", addrb_valid, 1);
    chk("h1_addra", addra, 8);

    // second block while reader stalls: discarded; clear on the final write loses to set
    sample_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ovr_clr = (i == 7);
      #1 chk("w2_addra", addra, 8 + i);
      tick();
    end
    sample_valid = 1'b0; ovr_clr = 1'b0;
    chk("ov_ovr", overrun, 1);
    chk("ov_switch", switch, 1);
    chk("ov_brdy", block_ready, 0);
    chk("ov_addra", addra, 8);
    chk("ov_addrb", addrb, 0);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("clr_ovr", overrun, 0);

    // read with stalls: 1,0,0,1 then continuous
    rd_ready = 1'b1; #1 chk("r_a0", addrb, 0); tick();
    rd_ready = 1'b0; #1 chk("r_h1", addrb, 1); tick();
    rd_ready = 1'b0; #1 chk("r_h2", addrb, 1); tick();
    rd_ready = 1'b1; #1 chk("r_a1", addrb, 1); tick();
    for (int i = 2; i < 8; i++) begin
      #1;
      chk("r_addrb", addrb, i);
      chk("r_rdch", rd_ch, i % 2);
      chk("r_last", rd_last, (i == 7) ? 1 : 0);
      tick();
    end
    rd_ready = 1'b0;
    chk("r_busy_end", busy, 0);
    chk("r_valid_end", addrb_valid, 0);
    chk("r_last_end", rd_last, 0);

    // refill bank 1 while idle
    sample_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 chk("w3_addra", addra, 8 + i);
      tick();
    end
    chk("h3_switch", switch, 0);
    chk("h3_brdy", block_ready, 1);
    chk("h3_addrb", addrb, 8);

    // read bank 1 while filling bank 0; last read and last write coincide
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("bb_addra", addra, i);
      chk("bb_addrb", addrb, 8 + i);
      chk("bb_last", rd_last, (i == 7) ? 1 : 0);
      tick();
    end
    sample_valid = 1'b0; rd_ready = 1'b0;
    chk("bb_ovr", overrun, 0);
    chk("bb_brdy", block_ready, 1);
    chk("bb_switch", switch, 1);
    chk("bb_busy", busy, 1);
    chk("bb_addrb_nxt", addrb, 0);
    tick();
    chk("bb_brdy_1cyc", block_ready, 0);

    // reset after a partial block
    sample_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("pr_addra", addra, 13);
    rst_n = 1'b0; sample_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_addra", addra, 0);
    chk("mr_switch", switch, 0);
    chk("mr_valid", addrb_valid, 0);
    chk("mr_ovr", overrun, 0);
    chk("mr_brdy", block_ready, 0);
    chk("mr_addrb", addrb, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ecg_pingpong_addr_unit.md
# ecg_pingpong_addr_unit

Parametrised ping-pong address generator for the ECG sample buffer. It is the next-generation replacement for the fixed single-channel address, bank-switch and fetch path. Incoming samples from NCH interleaved channels are written into one half of a dual-port memory through port A. The other, already-filled half is read out through port B under a ready/valid handshake to the processing control unit. Bank swap, block-ready signalling and overrun detection are handled internally.

## Interface
Parameters:
- ADDR_W, 12, memory address width for ports A and B.
- NCH, 2, number of interleaved channels, 1..8.
- BLOCK_LEN, 1024, samples per channel per bank. Requires 2*BLOCK_LEN*NCH <= 2^ADDR_W.
- DECIM, 2, read-side decimation factor. Used only with ECG_ADDR_DECIM_EN. BLOCK_LEN must be divisible by DECIM.

Ports (derived constants: CH_W = max(1, clog2(NCH)); BANK_SIZE = BLOCK_LEN*NCH):
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  gates write acceptance.
- sample_valid  in  1  one channel sample present this cycle.
- ovr_clr  in  1  clears sticky overrun.
- addra  out  ADDR_W  write address.
- wea  out  1  write enable, = sample_valid & enable.
- wr_ch  out  CH_W  channel of the current write.
- addrb  out  ADDR_W  read address.
- addrb_valid  out  1  addrb is valid.
- rd_ready  in  1  consumer accepts addrb.
- rd_ch  out  CH_W  channel of the current read.
- rd_last  out  1  final read address of the block.
- switch  out  1  current write bank. The read bank is ~switch.
- block_ready  out  1  one-cycle pulse when a bank fills and is handed to the read side.
- overrun  out  1  sticky: a block was discarded.
- busy  out  1  read engine in READ.

## Operation
- Write pointer wr_cnt runs 0..BANK_SIZE-1.
  - addra = switch*BANK_SIZE + wr_cnt.
  - wr_ch = wr_cnt mod NCH. Channels arrive in order 0..NCH-1.
- An accept is wea=1. wr_cnt increments on each accept.
- On an accept at wr_cnt = BANK_SIZE-1, wr_cnt wraps to 0 and the bank-full decision is made:
  - Read engine will be IDLE next cycle (IDLE now, or rd_last accepted this cycle): toggle switch, pulse block_ready, start READ on the just-filled bank.
  - Otherwise: no toggle, no block_ready, set overrun. The same bank is overwritten and the block is discarded.
- Read FSM states are IDLE and READ.
  - IDLE -> READ on a handover.
  - READ -> IDLE when addrb_valid & rd_ready & rd_last.
- In READ, addrb = ~switch*BANK_SIZE + idx*NCH + ch.
  - ch is the inner loop, 0..NCH-1.
  - idx is the outer loop, stepping by STEP (1, or DECIM with the macro), over 0..BLOCK_LEN-STEP.
  - Address and counters advance only on addrb_valid & rd_ready. Holding rd_ready low holds addrb stable.
- rd_last = READ & ch==NCH-1 & idx==BLOCK_LEN-STEP.
- addrb_valid = busy = (state==READ).
- overrun clears on ovr_clr. If a set and a clear occur in the same cycle, set wins.
- enable=0 freezes the write side. Read continues.

## Timing
- Reset values: switch=0, wr_cnt=0, FSM IDLE, idx=ch=0, overrun=0, block_ready=0. Therefore addra=0, addrb=BANK_SIZE, addrb_valid=0, busy=0, rd_last=0.
- addra, wr_ch, addrb, rd_ch, rd_last and switch are decoded from registers only. wea is combinational from its inputs.
- block_ready, the switch toggle and READ entry all appear in the cycle after the final write accept.
- Back-to-back: if the last read and last write accept coincide, the next block starts the following cycle with no gap and no overrun.
- Reset mid-block forces all reset values in the next cycle. A partially written block is lost and no block_ready is issued.

## Configuration
- ECG_ADDR_DECIM_EN defined: STEP=DECIM. The read side outputs BANK_SIZE/DECIM addresses per block, keeping every DECIM-th sample of each channel.
- ECG_ADDR_DECIM_EN undefined: STEP=1 and DECIM is ignored. All BANK_SIZE addresses are read.
- The write side is identical in both builds.

## Test plan
All scenarios use ADDR_W=12, NCH=2, BLOCK_LEN=4, BANK_SIZE=8.
- Reset release, 8 consecutive sample_valid with enable=1 -> addra 0..7, wr_ch alternating 0,1. Next cycle: switch=1, block_ready=1 for one cycle, addrb=0, addrb_valid=1.
- rd_ready=1 continuous, no macro -> addrb 0..7 on consecutive cycles, rd_last on 7, busy falls next cycle. With ECG_ADDR_DECIM_EN and DECIM=2 -> addrb 0,1,4,5, rd_last on 5.
- rd_ready toggled 1,0,0,1 during READ -> addrb holds its value while rd_ready=0. No address is skipped or repeated.
- Second block of 8 samples written (addra 8..15) while rd_ready=0 -> overrun=1, switch stays 1, no block_ready, next addra=8. ovr_clr pulse -> overrun=0.
- Last read accept in the same cycle as the 8th write accept -> no overrun, block_ready pulses, switch toggles, READ re-entered on the new bank.
- rst_n low for one cycle after 5 writes -> addra=0, switch=0, addrb_valid=0, overrun=0 next cycle.
